fir_filter_mac: RTL

Parametrised serial-MAC FIR filter, the successor to the fixed 3-bit-input FIR filter: a signed sample of width IN_W is accepted on each 600 kHz sample enable and convolved with TAPS run-time-loadable coefficients. One multiplier is time-shared over TAPS cycles of the 12 MHz clock. The result is saturated to OUT_W and presented with a one-cycle valid strobe. The block sits between the sample-rate enable generator and downstream decimation or DAC logic.

---
 rtl/fir_filter_mac_pkg.sv | 35 +++
 rtl/fir_filter_mac_if.sv | 44 ++++
 rtl/fir_filter_mac_coef_bank.sv | 51 +++++
 rtl/fir_filter_mac.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fir_filter_mac_pkg.sv
// rtl/fir_filter_mac_pkg.sv - shared types, width helper and saturation for the serial-MAC FIR filter
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Accumulator wide enough for TAPS full-precision products without overflow.
    function automatic int acc_w(input int in_w, input int coef_w, input int taps);
        return in_w + coef_w + $clog2(taps);
    endfunction

    // Clamp a sign-extended accumulator to the signed range of out_w bits.
    // When out_w covers the accumulator the value passes through unchanged.
    function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] value,
                                                      input int                 out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (out_w >= 64) begin
            return value;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_filter_mac_if.sv
// rtl/fir_filter_mac_if.sv - sample, coefficient-write and result signals of the FIR filter
interface fir_filter_mac_if #(
    parameter int IN_W   = 3,
    parameter int COEF_W = 6,
    parameter int TAPS   = 16,
    parameter int OUT_W  = 16
) ();
    localparam int ADDR_W = $clog2(TAPS);

    logic                     iEnSample_600kHz;
    logic signed [IN_W-1:0]   iFirIn;
    logic                     iCoefWr;
    logic [ADDR_W-1:0]        iCoefAddr;
    logic signed [COEF_W-1:0] iCoefData;
    logic signed [OUT_W-1:0]  oFirOut;
    logic                     oFirValid;
    logic                     oBusy;
    logic                     oOverrun;

    modport master (
        output iEnSample_600kHz,
        output iFirIn,
        output iCoefWr,
        output iCoefAddr,
        output iCoefData,
        input  oFirOut,
        input  oFirValid,
        input  oBusy,
        input  oOverrun
    );

    modport slave (
        input  iEnSample_600kHz,
        input  iFirIn,
        input  iCoefWr,
        input  iCoefAddr,
        input  iCoefData,
        output oFirOut,
        output oFirValid,
        output oBusy,
        output oOverrun
    );

endinterface

// File: rtl/fir_filter_mac_coef_bank.sv
// rtl/fir_filter_mac_coef_bank.sv - shadow/active coefficient banks with copy-on-accept and tap read mux
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int COEF_W = 6,
    parameter int TAPS   = 16,
    parameter int ADDR_W = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [COEF_W-1:0] data,
    input  logic                     copy,
    input  logic [ADDR_W-1:0]        rd_idx,
    output logic signed [COEF_W-1:0] rd_data
);
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];

    // Addresses at or beyond TAPS match no entry, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (wr && (addr == ADDR_W'(i))) begin
                    shadow[i] <= data;
                end
            end
        end
    end

    // A write landing in the accept cycle is forwarded into the active copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                active[i] <= '0;
            end
        end else if (copy) begin
            for (int i = 0; i < TAPS; i++) begin
                active[i] <= (wr && (addr == ADDR_W'(i))) ? data : shadow[i];
            end
        end
    end

    assign rd_data = active[rd_idx];

endmodule

// File: rtl/fir_filter_mac.sv
// rtl/fir_filter_mac.sv - serial-MAC FIR filter: delay line, IDLE/MAC/OUT sequencer, accumulator, saturated output
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int COEF_W = 6,
    parameter int TAPS   = 16,
    parameter int OUT_W  = 16
) (
    input  logic            iClk_12MHz,
    input  logic            iRsn,
    fir_filter_mac_if.slave bus
);
    localparam int ACC_W  = acc_w(IN_W, COEF_W, TAPS);
    localparam int K_W    = $clog2(TAPS);
    localparam int PROD_W = IN_W + COEF_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

    fir_state_t state;
    fir_state_t state_next;

    logic [K_W-1:0]           k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [IN_W-1:0]   x [TAPS];
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  out_sat;
    logic                     accept;
    logic                     drop;
    logic                     mac_last;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .ADDR_W (K_W)
    ) u_coef_bank (
        .clk     (iClk_12MHz),
        .rst_n   (iRsn),
        .wr      (bus.iCoefWr),
        .addr    (bus.iCoefAddr),
        .data    (bus.iCoefData),
        .copy    (accept),
        .rd_idx  (k),
        .rd_data (coef)
    );

    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        mac_last   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iEnSample_600kHz) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                drop = bus.iEnSample_600kHz;
                if (k == K_LAST) begin
                    mac_last   = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                drop       = bus.iEnSample_600kHz;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Full-precision signed product, sign-extended into the accumulator.
    assign prod    = x[k] * coef;
    assign acc_sum = acc + ACC_W'(prod);
    assign out_sat = OUT_W'(sat_to_out(64'(acc_sum), OUT_W));

    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else if (accept) begin
            x[0] <= bus.iFirIn;
            for (int i = 1; i < TAPS; i++) begin
                x[i] <= x[i-1];
            end
        end
    end

    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            k   <= '0;
            acc <= '0;
        end else if (accept) begin
            k   <= '0;
            acc <= '0;
        end else if (state == MAC) begin
            k   <= k + K_W'(1);
            acc <= acc_sum;
        end
    end

    // The last MAC edge registers the result so it is visible throughout OUT.
    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            bus.oFirOut   <= '0;
            bus.oFirValid <= 1'b0;
            bus.oBusy     <= 1'b0;
            bus.oOverrun  <= 1'b0;
        end else begin
            if (mac_last) begin
                bus.oFirOut <= out_sat;
            end
            bus.oFirValid <= mac_last;
            bus.oBusy     <= (state_next != IDLE);
            bus.oOverrun  <= bus.oOverrun | drop;
        end
    end

endmodule
